scan_test_controller: RTL and testbench

Sequencer that applies stored full-scan test patterns to the scan-inserted CPU netlist (26 scan cells, 8 primary inputs, 8 primary outputs). For each accepted pattern it drives scan_en and scan_in to load the chain, pulses one capture cycle with the primary inputs applied, and unloads the captured response. The unloaded response, together with the captured primary outputs, is compared against the expected response carried with the pattern. The block sits between the pattern source (tester interface or pattern ROM) and the CPU core's scan ports, and reports pass/fail per pattern plus running counts.

---
 rtl/scan_test_controller.sv | 163 ++++++++++++++++
 tb/tb_scan_test_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_test_controller.sv
// scan_test_controller
// Applies one full-scan pattern at a time to a single-chain CUT. Each pattern
// goes through four phases: load the chain serially, pulse one capture cycle,
// unload the captured response, then hold the result for a handshake.
// Every output is decoded from registered state, so the CUT and the result
// consumer never see a combinational path from any controller input.

module scan_test_controller #(
   parameter int CHAIN_LEN = 26,
   parameter int PI_W      = 8,
   parameter int PO_W      = 8,
   parameter int CNT_W     = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   // pattern source
   input  logic                      pat_valid,
   output logic                      pat_ready,
   input  logic [PI_W-1:0]           pat_pi,
   input  logic [CHAIN_LEN-1:0]      pat_ppi,
   input  logic [PO_W-1:0]           pat_exp_po,
   input  logic [CHAIN_LEN-1:0]      pat_exp_ppo,
   // CUT scan and functional ports
   output logic                      scan_en,
   output logic                      scan_in,
   input  logic                      scan_out,
   output logic                      capture_en,
   output logic [PI_W-1:0]           cut_pi,
   input  logic [PO_W-1:0]           cut_po,
   // result consumer
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic                      res_pass,
   output logic [PO_W+CHAIN_LEN-1:0] res_diff,
   output logic [CNT_W-1:0]          pat_count,
   output logic [CNT_W-1:0]          fail_count
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      CAPT   = 3'd2,
      UNLOAD = 3'd3,
      RESP   = 3'd4
   } state_t;

   // Counts 0..CHAIN_LEN-1 across one LOAD or UNLOAD phase.
   localparam int BC_W = $clog2(CHAIN_LEN + 1);
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(CHAIN_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t                   state;
   state_t                   state_next;
   logic [BC_W-1:0]          bit_cnt;
   logic [CHAIN_LEN-1:0]     load_sr;
   logic [PO_W-1:0]          exp_po;
   logic [CHAIN_LEN-1:0]     exp_ppo;
   logic [PO_W-1:0]          po_cap;
   logic [CHAIN_LEN-1:0]     ppo_cap;
   logic [PO_W+CHAIN_LEN-1:0] diff_raw;

   logic accept;
   logic last_bit;
   logic res_done;

   // pat_ready is a pure decode of IDLE, so acceptance needs only pat_valid there.
   assign accept   = (state == IDLE) && pat_valid;
   assign last_bit = (bit_cnt == LAST_BIT);
   assign res_done = (state == RESP) && res_ready;
   assign diff_raw = {po_cap, ppo_cap} ^ {exp_po, exp_ppo};

   // State register; reset abandons any pattern in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Phase sequencing: LOAD and UNLOAD each last CHAIN_LEN cycles, CAPT one.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept)   state_next = LOAD;
         LOAD:    if (last_bit) state_next = CAPT;
         CAPT:                  state_next = UNLOAD;
         UNLOAD:  if (last_bit) state_next = RESP;
         RESP:    if (res_ready) state_next = IDLE;
         default:               state_next = IDLE;
      endcase
   end

   // Bit counter restarts at each acceptance and at the end of capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_cnt <= '0;
      end else if (accept || state == CAPT) begin
         bit_cnt <= '0;
      end else if (state == LOAD || state == UNLOAD) begin
         bit_cnt <= last_bit ? '0 : bit_cnt + BC_W'(1);
      end
   end

   // Pattern latch: stimulus, expected response and the held primary inputs.
   // The MSB of load_sr is presented first so it travels furthest down the
   // chain and ends in cell CHAIN_LEN-1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         load_sr <= '0;
         exp_po  <= '0;
         exp_ppo <= '0;
         cut_pi  <= '0;
      end else if (accept) begin
         load_sr <= pat_ppi;
         exp_po  <= pat_exp_po;
         exp_ppo <= pat_exp_ppo;
         cut_pi  <= pat_pi;
      end else if (state == LOAD) begin
         load_sr <= {load_sr[CHAIN_LEN-2:0], 1'b0};
      end
   end

   // Response capture: primary outputs on the capture edge, then the chain
   // tail is sampled on the same edges the CUT shifts, tail cell first.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         po_cap  <= '0;
         ppo_cap <= '0;
      end else if (state == CAPT) begin
         po_cap <= cut_po;
      end else if (state == UNLOAD) begin
         ppo_cap <= {ppo_cap[CHAIN_LEN-2:0], scan_out};
      end
   end

   // Result counters advance on the result handshake and stick at all-ones.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pat_count  <= '0;
         fail_count <= '0;
      end else if (res_done) begin
         if (pat_count != CNT_MAX) begin
            pat_count <= pat_count + CNT_W'(1);
         end
         if ((diff_raw != '0) && (fail_count != CNT_MAX)) begin
            fail_count <= fail_count + CNT_W'(1);
         end
      end
   end

   // Output decode from registered state only.
   always_comb begin
      pat_ready  = (state == IDLE);
      scan_en    = (state == LOAD) || (state == UNLOAD);
      scan_in    = (state == LOAD) ? load_sr[CHAIN_LEN-1] : 1'b0;
      capture_en = (state == CAPT);
      res_valid  = (state == RESP);
      res_diff   = (state == RESP) ? diff_raw : '0;
      res_pass   = (state == RESP) && (diff_raw == '0);
   end

endmodule

// File: tb/tb_scan_test_controller.sv
// Directed bench for scan_test_controller with a loopback scan-chain CUT model
// and a queue of expected results filled when each pattern is offered.
// A second instance with 3-bit counters runs in lockstep to reach saturation.

module tb_scan_test_controller;

   localparam int N = 26;

   logic          clk;
   logic          reset;
   logic          pat_valid;
   logic [7:0]    pat_pi;
   logic [N-1:0]  pat_ppi;
   logic [7:0]    pat_exp_po;
   logic [N-1:0]  pat_exp_ppo;
   logic          scan_out;
   logic [7:0]    cut_po;
   logic          res_ready;

   logic          pat_ready, scan_en, scan_in, capture_en, res_valid, res_pass;
   logic [7:0]    cut_pi;
   logic [33:0]   res_diff;
   logic [15:0]   pat_count, fail_count;

   logic          s_pat_ready, s_scan_en, s_scan_in, s_capture_en, s_res_valid, s_res_pass;
   logic [7:0]    s_cut_pi;
   logic [33:0]   s_res_diff;
   logic [2:0]    s_pat_count, s_fail_count;

   scan_test_controller dut (
      .clk(clk), .reset(reset),
      .pat_valid(pat_valid), .pat_ready(pat_ready), .pat_pi(pat_pi), .pat_ppi(pat_ppi),
      .pat_exp_po(pat_exp_po), .pat_exp_ppo(pat_exp_ppo),
      .scan_en(scan_en), .scan_in(scan_in), .scan_out(scan_out), .capture_en(capture_en),
      .cut_pi(cut_pi), .cut_po(cut_po),
      .res_valid(res_valid), .res_ready(res_ready), .res_pass(res_pass), .res_diff(res_diff),
      .pat_count(pat_count), .fail_count(fail_count)
   );

   scan_test_controller #(.CNT_W(3)) dut_s (
      .clk(clk), .reset(reset),
      .pat_valid(pat_valid), .pat_ready(s_pat_ready), .pat_pi(pat_pi), .pat_ppi(pat_ppi),
      .pat_exp_po(pat_exp_po), .pat_exp_ppo(pat_exp_ppo),
      .scan_en(s_scan_en), .scan_in(s_scan_in), .scan_out(scan_out), .capture_en(s_capture_en),
      .cut_pi(s_cut_pi), .cut_po(cut_po),
      .res_valid(s_res_valid), .res_ready(res_ready), .res_pass(s_res_pass), .res_diff(s_res_diff),
      .pat_count(s_pat_count), .fail_count(s_fail_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // CUT model: cell 0 is the chain head, capture keeps each cell's content.
   logic [N-1:0] chain;
   logic         stuck;
   initial chain = '0;
   always @(posedge clk) begin
      if (scan_en) chain <= {chain[N-2:0], scan_in};
   end
   assign scan_out = chain[N-1];
   assign cut_po   = stuck ? 8'h00 : cut_pi;

   typedef struct {
      logic [7:0]   pi;
      logic [N-1:0] ppi;
      logic [33:0]  diff;
      logic         pass;
   } exp_t;
   exp_t sb_q[$];
   exp_t cur;

   int checks = 0;
   int errors = 0;
   int exp_pat = 0, exp_fail = 0, exp_spat = 0, exp_sfail = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive a pattern and record the response the loopback CUT should give.
   task automatic offer(input logic [7:0] pi, input logic [N-1:0] ppi,
                        input logic [7:0] epo, input logic [N-1:0] eppo);
      exp_t e;
      logic [7:0] po_model;
      pat_pi = pi; pat_ppi = ppi; pat_exp_po = epo; pat_exp_ppo = eppo;
      pat_valid = 1'b1;
      po_model = stuck ? 8'h00 : pi;
      e.pi   = pi;
      e.ppi  = ppi;
      e.diff = {po_model ^ epo, ppi ^ eppo};
      e.pass = (e.diff == 34'h0);
      sb_q.push_back(e);
   endtask

   // Returns at the negedge of the first LOAD cycle.
   task automatic wait_accept();
      int k;
      k = 0;
      while (!pat_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("accept_timeout", pat_ready, 1'b1);
      @(negedge clk);
      pat_valid = 1'b0;
   endtask

   // Follows one pattern from LOAD cycle 1 to its RESP cycle.
   task automatic wait_result(input bit chk_lat);
      int n;
      logic [N-1:0] seq;
      logic capt;
      n = 1; seq = '0; capt = 1'b0;
      while (!res_valid && n < 300) begin
         if (n <= N) seq[N-n] = scan_in;
         if (n == N + 1) capt = capture_en;
         @(negedge clk);
         n++;
      end
      cur = sb_q.pop_front();
      check("res_valid_timeout", res_valid, 1'b1);
      if (chk_lat) check("latency", n, 2 * N + 2);
      check("scan_in_seq", seq, cur.ppi);
      check("capture_pulse", capt, 1'b1);
      check("res_diff", res_diff, cur.diff);
      check("res_pass", res_pass, cur.pass);
      check("cut_pi", cut_pi, cur.pi);
      check("pat_ready_resp", pat_ready, 1'b0);
      check("s_res_valid", s_res_valid, 1'b1);
      check("s_res_diff", s_res_diff, cur.diff);
      check("s_res_pass", s_res_pass, cur.pass);
      check("s_cut_pi", s_cut_pi, cur.pi);
      check("s_idle_ports", {s_pat_ready, s_scan_en, s_scan_in, s_capture_en}, 4'b0000);
   endtask

   // Called at the negedge of a RESP cycle with res_ready high.
   task automatic handshake();
      @(negedge clk);
      if (exp_pat < 65535) exp_pat++;
      if (!cur.pass && exp_fail < 65535) exp_fail++;
      if (exp_spat < 7) exp_spat++;
      if (!cur.pass && exp_sfail < 7) exp_sfail++;
      check("pat_ready_idle", pat_ready, 1'b1);
      check("pat_count", pat_count, exp_pat[15:0]);
      check("fail_count", fail_count, exp_fail[15:0]);
      check("s_pat_count", s_pat_count, exp_spat[2:0]);
      check("s_fail_count", s_fail_count, exp_sfail[2:0]);
   endtask

   task automatic run(input logic [7:0] pi, input logic [N-1:0] ppi,
                      input logic [7:0] epo, input logic [N-1:0] eppo);
      offer(pi, ppi, epo, eppo);
      wait_accept();
      wait_result(1'b1);
      handshake();
   endtask

   initial begin
      logic [N-1:0] rp;
      logic [33:0]  held;
      reset = 1'b1; pat_valid = 1'b0; pat_pi = '0; pat_ppi = '0;
      pat_exp_po = '0; pat_exp_ppo = '0; res_ready = 1'b1; stuck = 1'b0;

      #3;
      check("rst_pat_ready", pat_ready, 1'b1);
      check("rst_outs", {scan_en, scan_in, capture_en, res_valid, res_pass}, 5'b0);
      check("rst_diff", res_diff, 34'h0);
      check("rst_counts", {pat_count, fail_count}, 32'h0);
      check("rst_cut_pi", cut_pi, 8'h00);
      @(negedge clk);
      reset = 1'b0;

      // Loopback, matching expectation.
      run(8'hA5, 26'h2AAAAAA, 8'hA5, 26'h2AAAAAA);
      // Expected chain bit 0 flipped: single-bit diff at the LSB.
      run(8'hA5, 26'h2AAAAAA, 8'hA5, 26'h2AAAAAB);
      // Primary outputs stuck at zero.
      stuck = 1'b1;
      run(8'hA5, 26'h2AAAAAA, 8'hA5, 26'h2AAAAAA);
      check("stuck_po_field", res_diff, 34'h0);
      stuck = 1'b0;
      rp = 26'($urandom);
      run(8'h3C, rp, 8'h3C, rp);

      // Result held while the consumer stalls; next pattern waits for IDLE.
      res_ready = 1'b0;
      offer(8'h5A, 26'h1234567, 8'h5A, 26'h1234567 ^ 26'h0100000);
      wait_accept();
      wait_result(1'b1);
      held = res_diff;
      check("held_diff_value", held, 34'h0100000);
      offer(8'hC3, 26'h0F0F0F0, 8'hC3, 26'h0F0F0F0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("hold_valid", res_valid, 1'b1);
         check("hold_diff", res_diff, held);
         check("hold_pat_ready", pat_ready, 1'b0);
      end
      res_ready = 1'b1;
      handshake();
      @(negedge clk);
      check("next_accepted_load", {scan_en, pat_ready}, 2'b10);
      pat_valid = 1'b0;
      wait_result(1'b0);
      handshake();

      // Asynchronous reset in LOAD cycle 10.
      offer(8'h11, 26'h3FFFFFF, 8'h11, 26'h3FFFFFF);
      wait_accept();
      repeat (9) @(negedge clk);
      check("pre_rst_scan_en", scan_en, 1'b1);
      #2 reset = 1'b1;
      #1;
      check("arst_outs", {scan_en, capture_en, res_valid}, 3'b000);
      check("arst_pat_ready", pat_ready, 1'b1);
      check("arst_counts", {pat_count, fail_count}, 32'h0);
      check("arst_s_counts", {s_pat_count, s_fail_count}, 6'h0);
      sb_q.delete();
      exp_pat = 0; exp_fail = 0; exp_spat = 0; exp_sfail = 0;
      @(negedge clk);
      reset = 1'b0;
      run(8'h77, 26'h2AAAAAA, 8'h77, 26'h2AAAAAA);

      // Repeated failures saturate the 3-bit counters of the second instance.
      for (int i = 0; i < 9; i++) begin
         rp = 26'($urandom);
         run(8'(i), rp, 8'(i) ^ 8'h80, rp);
      end
      check("s_fail_saturated", s_fail_count, 3'h7);
      check("fail_no_sat", fail_count, 16'd9);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
